// File: rtl/pad_input_mapper.sv
// Maps decoded pad words onto the M92 core's active-low player, coin, start and service inputs.
// Adds SOCD cleaning, frame-counted coin pulses, per-player autofire and a safe released state on link loss.
module pad_input_mapper #(
    parameter int unsigned COIN_FRAMES     = 3,
    parameter int unsigned AUTOFIRE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cont1_key,
    input  logic [31:0] cont2_key,
    input  logic        rx_timed_out,
    input  logic        vblank,
    output logic [7:0]  p1_n,
    output logic [7:0]  p2_n,
    output logic [1:0]  coin_n,
    output logic [1:0]  start_n,
    output logic        service_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] COIN_LAST = CNT_W'(COIN_FRAMES - 1);
    localparam logic [CNT_W-1:0] AF_LAST   = CNT_W'(AUTOFIRE_FRAMES - 1);

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_ACTIVE,
        COIN_HOLD
    } coin_state_t;

    logic             vblank_d;
    logic             vblank_rise;
    logic [1:0]       sel;
    logic [1:0]       sel_d;
    logic [1:0]       fire_x;
    logic [1:0]       coin_trig;
    logic             service;
    coin_state_t      coin_state [2];
    logic [CNT_W-1:0] coin_cnt [2];
    logic [CNT_W-1:0] af_cnt [2];
    logic [1:0]       af_phase;
    logic             unused_bits;

    assign vblank_rise = vblank & ~vblank_d;
    assign sel         = {cont2_key[14], cont1_key[14]};
    assign fire_x      = {cont2_key[6], cont1_key[6]};
    assign service     = cont1_key[8] & cont1_key[9] & cont1_key[14];
    // The service combo shares pad 1's select, so it must not also drop a coin.
    assign coin_trig   = sel & ~sel_d & {1'b1, ~service};
    assign unused_bits = ^{cont1_key[31:16], cont1_key[13:10], cont2_key[31:16], cont2_key[13:10]};

    // SOCD-cleaned directions plus button map, returned active-low.
    function automatic logic [7:0] map_pad(input logic [9:0] k, input logic phase);
        logic up, down, left, right;
        up    = k[0] & ~k[1];
        down  = k[1] & ~k[0];
        left  = k[2] & ~k[3];
        right = k[3] & ~k[2];
        return ~{k[8] & ~k[9], k[7], k[5], k[4] | (k[6] & phase), right, left, down, up};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_d  <= 1'b0;
            sel_d     <= '0;
            af_phase  <= '0;
            p1_n      <= '1;
            p2_n      <= '1;
            coin_n    <= '1;
            start_n   <= '1;
            service_n <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                coin_state[i] <= COIN_IDLE;
                coin_cnt[i]   <= '0;
                af_cnt[i]     <= '0;
            end
        end else begin
            vblank_d <= vblank;
            sel_d    <= sel;

            for (int i = 0; i < 2; i++) begin
                // Autofire: release re-arms phase high so the next press fires at once.
                if (rx_timed_out) begin
                    af_cnt[i] <= '0;
                end else if (!fire_x[i]) begin
                    af_cnt[i]   <= '0;
                    af_phase[i] <= 1'b1;
                end else if (vblank_rise) begin
                    if (af_cnt[i] == AF_LAST) begin
                        af_cnt[i]   <= '0;
                        af_phase[i] <= ~af_phase[i];
                    end else begin
                        af_cnt[i] <= af_cnt[i] + CNT_W'(1);
                    end
                end

                // Coin pulse: link loss parks in HOLD so a fresh select press is needed.
                if (rx_timed_out) begin
                    coin_state[i] <= COIN_HOLD;
                    coin_cnt[i]   <= '0;
                    coin_n[i]     <= 1'b1;
                end else begin
                    case (coin_state[i])
                        COIN_IDLE: begin
                            if (coin_trig[i]) begin
                                coin_state[i] <= COIN_ACTIVE;
                                coin_cnt[i]   <= '0;
                                coin_n[i]     <= 1'b0;
                            end
                        end
                        COIN_ACTIVE: begin
                            if (vblank_rise) begin
                                if (coin_cnt[i] == COIN_LAST) begin
                                    coin_state[i] <= COIN_HOLD;
                                    coin_n[i]     <= 1'b1;
                                end else begin
                                    coin_cnt[i] <= coin_cnt[i] + CNT_W'(1);
                                end
                            end
                        end
                        COIN_HOLD: begin
                            if (!sel[i]) begin
                                coin_state[i] <= COIN_IDLE;
                            end
                        end
                        default: begin
                            coin_state[i] <= COIN_IDLE;
                            coin_n[i]     <= 1'b1;
                        end
                    endcase
                end
            end

            if (rx_timed_out) begin
                p1_n      <= '1;
                p2_n      <= '1;
                start_n   <= '1;
                service_n <= 1'b1;
            end else begin
                p1_n      <= map_pad(cont1_key[9:0], af_phase[0]);
                p2_n      <= map_pad(cont2_key[9:0], af_phase[1]);
                start_n   <= ~{cont2_key[15], cont1_key[15]};
                service_n <= ~service;
            end
        end
    end

endmodule

// File: tb/tb_pad_input_mapper.sv
// Bench for pad_input_mapper: directed plan scenarios plus random traffic against a frame-level reference model.
module tb_pad_input_mapper;

    localparam int unsigned COIN = 3;
    localparam int unsigned AF   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cont1_key;
    logic [31:0] cont2_key;
    logic        rx_timed_out;
    logic        vblank;
    logic [7:0]  p1_n;
    logic [7:0]  p2_n;
    logic [1:0]  coin_n;
    logic [1:0]  start_n;
    logic        service_n;
    logic [20:0] got;

    int errors = 0;
    int checks = 0;
    int vc     = 0;

    // Reference model state: frames left in a coin pulse, release-pending flag, autofire rise count/phase.
    bit          m_vb;
    bit [1:0]    m_sel;
    int          m_rem [2];
    bit          m_wait [2];
    int          m_afn [2];
    bit          m_phase [2];
    logic [20:0] exp_o;

    pad_input_mapper #(.COIN_FRAMES(COIN), .AUTOFIRE_FRAMES(AF)) dut (
        .clk(clk), .reset(reset), .cont1_key(cont1_key), .cont2_key(cont2_key),
        .rx_timed_out(rx_timed_out), .vblank(vblank), .p1_n(p1_n), .p2_n(p2_n),
        .coin_n(coin_n), .start_n(start_n), .service_n(service_n)
    );

    assign got = {p1_n, p2_n, coin_n, start_n, service_n};

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_pad(input logic [31:0] k, input bit ph);
        logic [7:0] a;
        a[0] = k[0] && !k[1];
        a[1] = k[1] && !k[0];
        a[2] = k[2] && !k[3];
        a[3] = k[3] && !k[2];
        a[4] = k[4] || (k[6] && ph);
        a[5] = k[5];
        a[6] = k[7];
        a[7] = k[8] && !k[9];
        return ~a;
    endfunction

    task automatic model_reset();
        m_vb  = 1'b0;
        m_sel = '0;
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_wait[i] = 1'b0; m_afn[i] = 0; m_phase[i] = 1'b0;
        end
        exp_o = '1;
    endtask

    // Predict the outputs after the coming edge from the current inputs, then advance one clock.
    task automatic tick();
        logic [31:0] k [2];
        logic [7:0]  pn [2];
        bit          rise, svc;
        bit [1:0]    sel;
        k[0] = cont1_key;
        k[1] = cont2_key;
        rise = vblank && !m_vb;
        svc  = k[0][8] && k[0][9] && k[0][14];
        for (int i = 0; i < 2; i++) begin
            sel[i] = k[i][14];
            pn[i]  = ref_pad(k[i], m_phase[i]);
        end
        for (int i = 0; i < 2; i++) begin
            if (rx_timed_out) begin
                m_afn[i] = 0; m_rem[i] = 0; m_wait[i] = 1'b1;
            end else begin
                if (!k[i][6]) begin
                    m_afn[i] = 0; m_phase[i] = 1'b1;
                end else if (rise) begin
                    m_afn[i]++;
                    if (m_afn[i] % AF == 0) m_phase[i] = !m_phase[i];
                end
                if (m_rem[i] == 0 && m_wait[i] && !sel[i]) begin
                    m_wait[i] = 1'b0;
                end else if (m_rem[i] == 0 && !m_wait[i] && sel[i] && !m_sel[i] && !(i == 0 && svc)) begin
                    m_rem[i] = COIN; m_wait[i] = 1'b1;
                end else if (m_rem[i] > 0 && rise) begin
                    m_rem[i]--;
                end
            end
        end
        if (rx_timed_out) exp_o = '1;
        else exp_o = {pn[0], pn[1], (m_rem[1] == 0), (m_rem[0] == 0), ~{k[1][15], k[0][15]}, !svc};
        m_vb  = vblank;
        m_sel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (got !== 21'h1F_FFFF) begin errors++; $display("FAIL reset_state: got %h want 1fffff", got); end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL reset_idle: got %h want %h", got, exp_o); end
        end
    endtask

    task automatic test_directions();
        logic [31:0] pat [3];
        logic [7:0]  want [3];
        pat[0] = 32'h0000_0001; want[0] = 8'hFE;
        pat[1] = 32'h0000_000C; want[1] = 8'hFF;
        pat[2] = 32'h0000_0005; want[2] = 8'hFA;
        for (int j = 0; j < 3; j++) begin
            cont1_key = pat[j];
            tick();
            checks++;
            if (p1_n !== want[j]) begin errors++; $display("FAIL dir_p1[%0d]: got %h want %h", j, p1_n, want[j]); end
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL dir_others[%0d]: got %h want %h", j, got, exp_o); end
        end
        for (int c = 0; c < 20; c++) begin
            cont2_key = $urandom() & 32'h0000_03BF;
            tick();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL dir_rand: got %h want %h", got, exp_o); end
        end
        cont1_key = '0; cont2_key = '0;
        tick();
    endtask

    task automatic test_coin();
        int  low;
        bit  pv;
        low = 0; pv = m_vb;
        vc  = 0;
        for (int c = 0; c < 60; c++) begin
            vblank    = (vc % 6) < 2;
            cont2_key = 32'h0000_4000;
            if (vblank && !pv && coin_n[1] === 1'b0) low++;
            pv = vblank;
            tick(); vc++;
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL coin_hold: got %h want %h", got, exp_o); end
        end
        checks++;
        if (low != COIN) begin errors++; $display("FAIL coin_frames: got %0d want %0d", low, COIN); end
        cont2_key = '0;
        for (int c = 0; c < 6; c++) begin
            vblank = (vc % 6) < 2; pv = vblank;
            tick(); vc++;
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL coin_release: got %h want %h", got, exp_o); end
        end
        low = 0;
        for (int c = 0; c < 30; c++) begin
            vblank    = (vc % 6) < 2;
            cont2_key = 32'h0000_4000;
            if (vblank && !pv && coin_n[1] === 1'b0) low++;
            pv = vblank;
            tick(); vc++;
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL coin_repress: got %h want %h", got, exp_o); end
        end
        checks++;
        if (low != COIN) begin errors++; $display("FAIL coin_second: got %0d want %0d", low, COIN); end
        cont2_key = '0; vblank = 1'b0;
        tick();
    endtask

    task automatic test_autofire();
        int   toggles;
        logic last;
        vblank = 1'b0; vc = 2;
        cont1_key = 32'h0000_0040;
        tick(); vc++;
        checks++;
        if (p1_n[4] !== 1'b0) begin errors++; $display("FAIL af_first: got %b want 0", p1_n[4]); end
        last = p1_n[4]; toggles = 0;
        while (vc <= 76) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL af_track: got %h want %h", got, exp_o); end
            if (p1_n[4] !== last) toggles++;
            last = p1_n[4];
        end
        checks++;
        if (toggles != 6) begin errors++; $display("FAIL af_toggles: got %0d want 6", toggles); end
        cont1_key = 32'h0000_0050;
        for (int c = 0; c < 36; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
            checks++;
            if (p1_n[4] !== 1'b0 || got !== exp_o) begin
                errors++; $display("FAIL af_with_a: got %h want %h", got, exp_o);
            end
        end
        cont1_key = '0; vblank = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        cont1_key = 32'h0000_4001; vc = 2;
        for (int c = 0; c < 8; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
        end
        checks++;
        if (coin_n[0] !== 1'b0 || got !== exp_o) begin
            errors++; $display("FAIL to_coin_active: got %h want %h", got, exp_o);
        end
        rx_timed_out = 1'b1;
        tick();
        checks++;
        if (got !== 21'h1F_FFFF) begin errors++; $display("FAIL to_forced: got %h want 1fffff", got); end
        for (int c = 0; c < 5; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL to_held: got %h want %h", got, exp_o); end
        end
        rx_timed_out = 1'b0;
        tick(); vc++;
        checks++;
        if (p1_n !== 8'hFE || coin_n[0] !== 1'b1) begin
            errors++; $display("FAIL to_resume: got p1_n=%h coin_n=%b want fe/1", p1_n, coin_n);
        end
        for (int c = 0; c < 18; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
            checks++;
            if (coin_n[0] !== 1'b1 || got !== exp_o) begin
                errors++; $display("FAIL to_no_coin: got %h want %h", got, exp_o);
            end
        end
        cont1_key = 32'h0000_0001;
        tick(); tick();
        cont1_key = 32'h0000_4001;
        tick();
        checks++;
        if (coin_n[0] !== 1'b0 || got !== exp_o) begin
            errors++; $display("FAIL to_recoin: got %h want %h", got, exp_o);
        end
        cont1_key = '0; vblank = 1'b0;
        for (int c = 0; c < 24; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
        end
    endtask

    task automatic test_service();
        cont1_key = 32'h0000_4300;
        for (int c = 0; c < 18; c++) begin
            vblank = (vc % 6) < 2;
            tick(); vc++;
            checks++;
            if (service_n !== 1'b0 || coin_n[0] !== 1'b1 || got !== exp_o) begin
                errors++; $display("FAIL service: got %h want %h", got, exp_o);
            end
        end
        cont1_key = '0;
        tick();
        checks++;
        if (got !== exp_o) begin errors++; $display("FAIL service_off: got %h want %h", got, exp_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) cont1_key = $urandom();
            if ($urandom_range(3) == 0) cont2_key = $urandom();
            vblank       = ($urandom_range(4) == 0) ? ~vblank : vblank;
            rx_timed_out = ($urandom_range(24) == 0);
            tick();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL random[%0d]: got %h want %h", c, got, exp_o); end
        end
        rx_timed_out = 1'b0;
    endtask

    task automatic test_async_reset();
        cont1_key = 32'h0000_4001; cont2_key = 32'h0000_8010; vblank = 1'b0;
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (got !== 21'h1F_FFFF) begin errors++; $display("FAIL async_reset: got %h want 1fffff", got); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cont1_key = '0; cont2_key = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (got !== exp_o) begin errors++; $display("FAIL post_reset: got %h want %h", got, exp_o); end
        end
    endtask

    initial begin
        reset = 1'b1; cont1_key = '0; cont2_key = '0; rx_timed_out = 1'b0; vblank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        test_reset();
        test_directions();
        test_coin();
        test_autofire();
        test_timeout();
        test_service();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
